pin_collision: RTL and testbench
================================

Name: pin_collision

Overview:
- Upstream stage of `pins`: decides which pins the ball strikes and what velocity each struck pin receives.
- On each frame tick it snapshots ball state and the fed-back pin positions.
- It scans the 10 pins sequentially, one per cycle, using a squared-distance test.
- It then emits one valid pulse with sticky hit flags and per-pin velocities, which drive `pins` inputs `valid_in`, `pins_hit_in`, `pins_vx_in`, `pins_vy_in` and `is_vy_neg`.

Parameters:
- HIT_RADIUS_SQ, 1024: hit threshold on dx²+dy², in pixels².
- VEL_SHIFT, 1: right shift applied to ball velocity to form a struck pin's velocity.
- SCREEN_WIDTH, 1024: ball_x at or above this is offscreen.
- SCREEN_HEIGHT, 768: ball_y at or above this is offscreen.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rst_sim  input  1  synchronous active-high simulation restart.
- valid_in  input  1  frame tick; a request to evaluate collisions.
- ball_x  input  11  ball x position, pixels.
- ball_y  input  10  ball y position, pixels.
- ball_vx  input  16  ball x speed magnitude.
- ball_vy  input  16  ball y speed magnitude.
- ball_vy_neg  input  1  ball y-direction flag.
- pins_x  input  [9:0][10:0]  current pin x positions (from `pins`).
- pins_y  input  [9:0][9:0]  current pin y positions (from `pins`).
- valid_out  output  1  one-cycle result strobe.
- pins_hit_out  output  10  sticky hit flags.
- pins_vx_out  output  [9:0][15:0]  per-pin x velocity.
- pins_vy_out  output  [9:0][15:0]  per-pin y velocity.
- is_vy_neg_out  output  1  direction flag latched at snapshot.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state goes to IDLE.
  - All outputs and the snapshot registers go to 0.
  - rst_in takes effect mid-scan with no partial result.
- rst_sim high at a clock edge: same clearing as reset, applied synchronously. It wins over a simultaneous valid_in.
- FSM states:
  - IDLE: when valid_in=1, snapshot all ball and pin inputs, set idx=0, go to SCAN.
  - SCAN: evaluate pin[idx] each cycle. At idx=9, go to DONE; otherwise idx+1.
  - DONE: valid_out=1 for exactly one cycle, then IDLE, or CHAIN when PIN_CHAIN_EN is defined.
- Latency: valid_out is asserted 11 cycles after the accepting edge (10 SCAN cycles plus DONE).
- valid_in while busy=1 is ignored, not queued.
- Hit test:
  - dx = ball_x − pin_x, signed 12-bit.
  - dy = ball_y − pin_y, sign-extended to 12-bit.
  - d2 = dx² + dy², unsigned 24-bit, no overflow possible.
  - A hit occurs when d2 ≤ HIT_RADIUS_SQ. Equality counts as a hit.
- Offscreen ball (ball_x ≥ SCREEN_WIDTH or ball_y ≥ SCREEN_HEIGHT): no new hits this frame. The scan still runs and valid_out still fires.
- First hit on pin i:
  - set pins_hit_out[i].
  - pins_vx_out[i] = ball_vx >> VEL_SHIFT.
  - pins_vy_out[i] = ball_vy >> VEL_SHIFT.
- Already-hit pin: its flag and velocities are held unchanged. There is no re-hit and no accumulation.
- A zero resulting velocity still sets the hit flag.
- is_vy_neg_out updates at snapshot and holds until the next accept or reset.
- Outputs are stable between valid_out pulses.

Optional Feature:
- Macro: PIN_CHAIN_EN.
- Defined:
  - DONE is followed by a CHAIN state that runs 10 further cycles.
  - For each un-hit pin j, any pin k already hit at the end of SCAN with |pin_j − pin_k|² ≤ HIT_RADIUS_SQ hits j.
  - Pin j takes pin k's velocities >> 1, using the lowest such k.
  - Pins first hit during CHAIN do not propagate further in the same pass.
  - A second valid_out pulse fires at the end of CHAIN. Latency is 22 cycles to the final pulse.
  - busy stays high through CHAIN.
- Undefined: no pin-pin interaction; a single valid_out per frame.

Decomposition:
- Package `bowling_pkg`:
  - NUM_PINS = 10.
  - X_W = 11, Y_W = 10, V_W = 16.
  - DIST_W = 24.
  - typedef coll_state_t {IDLE, SCAN, DONE, CHAIN}.
- Sub-module `pin_hit_check`:
  - Combinational.
  - Inputs: two points and a threshold.
  - Output: hit bit.
  - Instanced once for ball-vs-pin and reused for pin-vs-pin.

Test Plan:
- Ball (20,24) with pin 0 at (0,0), VEL_SHIFT=1, vx=16, vy=40 → after 11 cycles valid_out=1, hit=0x001, vx[0]=8, vy[0]=20.
- Ball (32,0) vs pin 0 at (0,0) → hit=0x001, since d2=1024 equals the threshold. Ball (33,0) → hit=0x000.
- Pin 0 already hit, then ball hits pin 1 (96,0) with vx=100 → vx[0] unchanged, vx[1]=50, hit=0x003.
- valid_in pulsed on cycles 1 and 5 → exactly one valid_out, at cycle 12. rst_in low at cycle 6 → outputs 0, busy=0, no pulse.
- ball_x=1030 sitting on pin 3's coordinates → hit=0x000, valid_out still fires.
- PIN_CHAIN_EN defined, pin 9 moved to (0,30), ball hits pin 0 only with vx=16 → first pulse hit=0x001, second pulse hit=0x201, vx[9]=4.

Source files
------------

// File: rtl/bowling_pkg.sv
// Shared widths and collision FSM state type for the bowling datapath.
// Used by pin_collision and pin_hit_check.
package bowling_pkg;
  localparam int NUM_PINS = 10;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int V_W      = 16;
  localparam int DIST_W   = 24;
  localparam int D_W      = 12;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE,
    CHAIN
  } coll_state_t;
endpackage

// File: rtl/pin_hit_check.sv
// Combinational squared-distance proximity test between two screen points.
// Hit when dx^2 + dy^2 <= i_thr (equality counts).
module pin_hit_check
  import bowling_pkg::*;
(
  input  logic [X_W-1:0]    i_ax,
  input  logic [Y_W-1:0]    i_ay,
  input  logic [X_W-1:0]    i_bx,
  input  logic [Y_W-1:0]    i_by,
  input  logic [DIST_W-1:0] i_thr,
  output logic              o_hit
);
  logic signed [D_W-1:0]    w_dx;
  logic signed [D_W-1:0]    w_dy;
  logic signed [DIST_W-1:0] w_sx;
  logic signed [DIST_W-1:0] w_sy;
  logic [DIST_W-1:0]        w_d2;

  assign w_dx  = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
  assign w_dy  = $signed({2'b0, i_ay}) - $signed({2'b0, i_by});
  assign w_sx  = w_dx * w_dx;
  assign w_sy  = w_dy * w_dy;
  assign w_d2  = $unsigned(w_sx) + $unsigned(w_sy);
  assign o_hit = (w_d2 <= i_thr);
endmodule

// File: rtl/pin_collision.sv
// Ball-vs-pin collision scanner: one pin per cycle, sticky hit flags.
// Optional pin-to-pin chain pass enabled by defining PIN_CHAIN_EN.
module pin_collision
  import bowling_pkg::*;
#(
  parameter int HIT_RADIUS_SQ = 1024,
  parameter int VEL_SHIFT     = 1,
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 768
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rst_sim,
  input  logic                          valid_in,
  input  logic [X_W-1:0]                ball_x,
  input  logic [Y_W-1:0]                ball_y,
  input  logic [V_W-1:0]                ball_vx,
  input  logic [V_W-1:0]                ball_vy,
  input  logic                          ball_vy_neg,
  input  logic [NUM_PINS-1:0][X_W-1:0]  pins_x,
  input  logic [NUM_PINS-1:0][Y_W-1:0]  pins_y,
  output logic                          valid_out,
  output logic [NUM_PINS-1:0]           pins_hit_out,
  output logic [NUM_PINS-1:0][V_W-1:0]  pins_vx_out,
  output logic [NUM_PINS-1:0][V_W-1:0]  pins_vy_out,
  output logic                          is_vy_neg_out,
  output logic                          busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PINS - 1);

  coll_state_t                  r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [X_W-1:0]               r_bx;
  logic [Y_W-1:0]               r_by;
  logic [V_W-1:0]               r_bvx;
  logic [V_W-1:0]               r_bvy;
  logic                         r_off;
  logic [NUM_PINS-1:0][X_W-1:0] r_px;
  logic [NUM_PINS-1:0][Y_W-1:0] r_py;
  // Working state; outputs only copy it at DONE so they stay stable mid-scan
  logic [NUM_PINS-1:0]          r_hit;
  logic [NUM_PINS-1:0][V_W-1:0] r_vx;
  logic [NUM_PINS-1:0][V_W-1:0] r_vy;

  logic [DIST_W-1:0] w_thr;
  logic              w_ball_hit;

  assign w_thr = DIST_W'(HIT_RADIUS_SQ);
  assign busy  = (r_state != IDLE);

  pin_hit_check u_ball (
    .i_ax  (r_bx),
    .i_ay  (r_by),
    .i_bx  (r_px[r_idx]),
    .i_by  (r_py[r_idx]),
    .i_thr (w_thr),
    .o_hit (w_ball_hit)
  );

`ifdef PIN_CHAIN_EN
  logic [NUM_PINS-1:0] r_src;
  logic                r_chained;
  logic [NUM_PINS-1:0] w_pp;
  logic [NUM_PINS-1:0] w_cand;
  logic [IDX_W-1:0]    w_k;
  logic                w_any;

  for (genvar k = 0; k < NUM_PINS; k++) begin : g_pp
    pin_hit_check u_pp (
      .i_ax  (r_px[r_idx]),
      .i_ay  (r_py[r_idx]),
      .i_bx  (r_px[k]),
      .i_by  (r_py[k]),
      .i_thr (w_thr),
      .o_hit (w_pp[k])
    );
  end

  assign w_cand = w_pp & r_src;

  // Descending walk so the lowest candidate index wins
  always_comb begin
    w_k   = '0;
    w_any = 1'b0;
    for (int k = NUM_PINS - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        w_k   = IDX_W'(k);
        w_any = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_bx          <= '0;
      r_by          <= '0;
      r_bvx         <= '0;
      r_bvy         <= '0;
      r_off         <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_hit         <= '0;
      r_vx          <= '0;
      r_vy          <= '0;
      valid_out     <= 1'b0;
      pins_hit_out  <= '0;
      pins_vx_out   <= '0;
      pins_vy_out   <= '0;
      is_vy_neg_out <= 1'b0;
`ifdef PIN_CHAIN_EN
      r_src         <= '0;
      r_chained     <= 1'b0;
`endif
    end else if (rst_sim) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_bx          <= '0;
      r_by          <= '0;
      r_bvx         <= '0;
      r_bvy         <= '0;
      r_off         <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_hit         <= '0;
      r_vx          <= '0;
      r_vy          <= '0;
      valid_out     <= 1'b0;
      pins_hit_out  <= '0;
      pins_vx_out   <= '0;
      pins_vy_out   <= '0;
      is_vy_neg_out <= 1'b0;
`ifdef PIN_CHAIN_EN
      r_src         <= '0;
      r_chained     <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_bx          <= ball_x;
            r_by          <= ball_y;
            r_bvx         <= ball_vx;
            r_bvy         <= ball_vy;
            r_off         <= (ball_x >= X_W'(SCREEN_WIDTH)) ||
                             (ball_y >= Y_W'(SCREEN_HEIGHT));
            r_px          <= pins_x;
            r_py          <= pins_y;
            is_vy_neg_out <= ball_vy_neg;
            r_idx         <= '0;
            r_state       <= SCAN;
          end
        end
        SCAN: begin
          if (w_ball_hit && !r_off && !r_hit[r_idx]) begin
            r_hit[r_idx] <= 1'b1;
            r_vx[r_idx]  <= r_bvx >> VEL_SHIFT;
            r_vy[r_idx]  <= r_bvy >> VEL_SHIFT;
          end
          if (r_idx == LAST) begin
            r_state <= DONE;
`ifdef PIN_CHAIN_EN
            r_chained <= 1'b0;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          valid_out    <= 1'b1;
          pins_hit_out <= r_hit;
          pins_vx_out  <= r_vx;
          pins_vy_out  <= r_vy;
`ifdef PIN_CHAIN_EN
          if (r_chained) begin
            r_state <= IDLE;
          end else begin
            r_src   <= r_hit;
            r_idx   <= '0;
            r_state <= CHAIN;
          end
`else
          r_state <= IDLE;
`endif
        end
        CHAIN: begin
`ifdef PIN_CHAIN_EN
          // Sources are frozen at end of SCAN, so new chain hits never spread
          if (!r_src[r_idx] && w_any) begin
            r_hit[r_idx] <= 1'b1;
            r_vx[r_idx]  <= r_vx[w_k] >> 1;
            r_vy[r_idx]  <= r_vy[w_k] >> 1;
          end
          if (r_idx == LAST) begin
            r_chained <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pin_collision.sv
// Self-checking bench for pin_collision: directed table, hand sequences,
// and randomized frames against a distance-rule reference model.
module tb_pin_collision;
  localparam int NP  = 10;
  localparam int VSH = 1;
  localparam int THR = 1024;
`ifdef PIN_CHAIN_EN
  localparam int NPULSE = 2;
`else
  localparam int NPULSE = 1;
`endif

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rst_sim;
  logic                 valid_in;
  logic [10:0]          ball_x;
  logic [9:0]           ball_y;
  logic [15:0]          ball_vx;
  logic [15:0]          ball_vy;
  logic                 ball_vy_neg;
  logic [9:0][10:0]     pins_x;
  logic [9:0][9:0]      pins_y;
  logic                 valid_out;
  logic [9:0]           pins_hit_out;
  logic [9:0][15:0]     pins_vx_out;
  logic [9:0][15:0]     pins_vy_out;
  logic                 is_vy_neg_out;
  logic                 busy;

  always #5 clk_in = ~clk_in;

  pin_collision dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rst_sim       (rst_sim),
    .valid_in      (valid_in),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .ball_vx       (ball_vx),
    .ball_vy       (ball_vy),
    .ball_vy_neg   (ball_vy_neg),
    .pins_x        (pins_x),
    .pins_y        (pins_y),
    .valid_out     (valid_out),
    .pins_hit_out  (pins_hit_out),
    .pins_vx_out   (pins_vx_out),
    .pins_vy_out   (pins_vy_out),
    .is_vy_neg_out (is_vy_neg_out),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;
  int px[NP];
  int py[NP];
  bit m_hit[NP];
  int m_vx[NP];
  int m_vy[NP];
  logic [9:0] first_hit;

  typedef struct {
    logic       clr;
    int         bx, by, vx, vy;
    int         mp, mx, my;
    logic [9:0] e_first, e_hit;
    int         cp, cvx, cvy;
  } vec_t;
  vec_t tbl[9];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int d2(input int ax, ay, bx, by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      m_hit[i] = 0;
      m_vx[i]  = 0;
      m_vy[i]  = 0;
    end
  endtask

  task automatic model_frame(input int bx, by, vx, vy);
    bit src[NP];
    if (bx < 1024 && by < 768)
      for (int i = 0; i < NP; i++)
        if (!m_hit[i] && d2(bx, by, px[i], py[i]) <= THR) begin
          m_hit[i] = 1;
          m_vx[i]  = vx / (1 << VSH);
          m_vy[i]  = vy / (1 << VSH);
        end
`ifdef PIN_CHAIN_EN
    src = m_hit;
    for (int j = 0; j < NP; j++) begin
      if (src[j]) continue;
      for (int k = 0; k < NP; k++)
        if (src[k] && d2(px[j], py[j], px[k], py[k]) <= THR) begin
          m_hit[j] = 1;
          m_vx[j]  = m_vx[k] / 2;
          m_vy[j]  = m_vy[k] / 2;
          break;
        end
    end
`endif
  endtask

  task automatic cmp_model(input string tag);
    logic [9:0] mask;
    for (int i = 0; i < NP; i++) mask[i] = m_hit[i];
    chk({tag, "_hitmask"}, pins_hit_out, mask);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s_vx%0d", tag, i), pins_vx_out[i], m_vx[i]);
      chk($sformatf("%s_vy%0d", tag, i), pins_vy_out[i], m_vy[i]);
    end
  endtask

  task automatic layout_default();
    for (int i = 0; i < NP; i++) begin
      px[i] = 96 * i;
      py[i] = 0;
    end
  endtask

  task automatic drive(input int bx, by, vx, vy, input logic neg);
    for (int i = 0; i < NP; i++) begin
      pins_x[i] = 11'(px[i]);
      pins_y[i] = 10'(py[i]);
    end
    ball_x      = 11'(bx);
    ball_y      = 10'(by);
    ball_vx     = 16'(vx);
    ball_vy     = 16'(vy);
    ball_vy_neg = neg;
  endtask

  task automatic sim_clear();
    rst_sim = 1'b1;
    tick();
    rst_sim = 1'b0;
    model_clear();
    chk("simclr_hit", pins_hit_out, 0);
  endtask

  task automatic frame(input int bx, by, vx, vy, input logic neg);
    int n, pulses;
    drive(bx, by, vx, vy, neg);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    model_frame(bx, by, vx, vy);
    n = 0;
    pulses = 0;
    while (pulses < NPULSE && n < 40) begin
      tick();
      n++;
      if (valid_out) begin
        pulses++;
        if (pulses == 1) begin
          first_hit = pins_hit_out;
          chk("lat_first", n, 11);
        end else begin
          chk("lat_final", n, 22);
        end
      end
    end
    chk("pulse_count", pulses, NPULSE);
    chk("busy_end", busy, 0);
    chk("vyneg", is_vy_neg_out, neg);
    tick();
    chk("strobe_len", valid_out, 0);
  endtask

  initial begin
    int pulses, first_n;
    rst_in   = 1'b0;
    rst_sim  = 1'b0;
    valid_in = 1'b0;
    layout_default();
    drive(0, 0, 0, 0, 1'b0);
    model_clear();
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_hit", pins_hit_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vx0", pins_vx_out[0], 0);
    chk("rst_vyneg", is_vy_neg_out, 0);
    #10 rst_in = 1'b1;
    tick();

    tbl[0] = '{1, 20, 24, 16, 40, -1, 0, 0, 10'h001, 10'h001, 0, 8, 20};
    tbl[1] = '{1, 32, 0, 16, 40, -1, 0, 0, 10'h001, 10'h001, 0, 8, 20};
    tbl[2] = '{0, 96, 0, 100, 0, -1, 0, 0, 10'h003, 10'h003, 1, 50, 0};
    tbl[3] = '{1, 33, 0, 16, 40, -1, 0, 0, 10'h000, 10'h000, 0, 0, 0};
    tbl[4] = '{1, 1030, 0, 50, 50, 3, 1030, 0, 10'h000, 10'h000, 3, 0, 0};
    tbl[5] = '{1, 500, 768, 50, 50, 4, 500, 768, 10'h000, 10'h000, 4, 0, 0};
    tbl[6] = '{1, 500, 767, 30, 10, 4, 500, 767, 10'h010, 10'h010, 4, 15, 5};
`ifdef PIN_CHAIN_EN
    tbl[7] = '{1, 31, 0, 16, 8, 9, 0, 30, 10'h001, 10'h201, 9, 4, 2};
`else
    tbl[7] = '{1, 31, 0, 16, 8, 9, 0, 30, 10'h001, 10'h001, 9, 0, 0};
`endif
    tbl[8] = '{1, 1023, 0, 7, 3, 9, 1023, 0, 10'h200, 10'h200, 9, 3, 1};

    foreach (tbl[t]) begin
      if (tbl[t].clr) sim_clear();
      layout_default();
      if (tbl[t].mp >= 0) begin
        px[tbl[t].mp] = tbl[t].mx;
        py[tbl[t].mp] = tbl[t].my;
      end
      frame(tbl[t].bx, tbl[t].by, tbl[t].vx, tbl[t].vy, 1'(t));
      chk($sformatf("t%0d_first", t), first_hit, tbl[t].e_first);
      chk($sformatf("t%0d_hit", t), pins_hit_out, tbl[t].e_hit);
      chk($sformatf("t%0d_vx", t), pins_vx_out[tbl[t].cp], tbl[t].cvx);
      chk($sformatf("t%0d_vy", t), pins_vy_out[tbl[t].cp], tbl[t].cvy);
      cmp_model($sformatf("t%0d", t));
    end

    // second valid_in while busy must be dropped
    sim_clear();
    layout_default();
    drive(32, 0, 16, 40, 1'b0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    model_frame(32, 0, 16, 40);
    pulses = 0;
    first_n = 0;
    for (int c = 1; c <= 30; c++) begin
      valid_in = (c == 4);
      tick();
      if (valid_out) begin
        pulses++;
        if (pulses == 1) first_n = c;
      end
    end
    valid_in = 1'b0;
    chk("busy_ign_pulses", pulses, NPULSE);
    chk("busy_ign_lat", first_n, 11);
    cmp_model("busy_ign");

    // async reset in the middle of a scan
    drive(96, 0, 100, 60, 1'b1);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_hit", pins_hit_out, 0);
    chk("mid_rst_vx0", pins_vx_out[0], 0);
    chk("mid_rst_vyneg", is_vy_neg_out, 0);
    #3 rst_in = 1'b1;
    model_clear();
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (valid_out) pulses++;
    end
    chk("mid_rst_nopulse", pulses, 0);
    cmp_model("mid_rst");

    // rst_sim beats a simultaneous valid_in
    layout_default();
    frame(32, 0, 16, 40, 1'b1);
    chk("pre_sim_hit", pins_hit_out, 10'h001);
    rst_sim  = 1'b1;
    valid_in = 1'b1;
    tick();
    rst_sim  = 1'b0;
    valid_in = 1'b0;
    model_clear();
    chk("simwin_busy", busy, 0);
    chk("simwin_hit", pins_hit_out, 0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (valid_out) pulses++;
    end
    chk("simwin_nopulse", pulses, 0);

    // randomized frames with sticky accumulation across frames
    for (int r = 0; r < 40; r++) begin
      int bx, by;
      if (r % 8 == 0) sim_clear();
      for (int i = 0; i < NP; i++) begin
        px[i] = int'($urandom_range(0, 200));
        py[i] = int'($urandom_range(0, 150));
      end
      if ($urandom_range(0, 4) == 0) begin
        bx = int'($urandom_range(0, 1100));
        by = int'($urandom_range(0, 1023));
      end else begin
        bx = int'($urandom_range(0, 240));
        by = int'($urandom_range(0, 190));
      end
      frame(bx, by, int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      cmp_model($sformatf("r%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
